// File: rtl/hp_ctrl_pkg.sv
// rtl/hp_ctrl_pkg.sv - shared state encoding, defaults and HP-to-bitmap mapping for the HP controller
package hp_ctrl_pkg;

  typedef enum logic [1:0] {ALIVE_ST, HIT_ST, INVULN_ST, DEAD_ST} state_t;

  localparam int HP_MAX_DEF        = 100;
  localparam int HP_STEP_DEF       = 25;
  localparam int INVULN_FRAMES_DEF = 30;

  // Floor division makes a clamped final hit land on the last bitmap index.
  function automatic logic [2:0] hp_level_of(input logic [6:0] hp, input int hp_max, input int hp_step);
    int lvl;
    lvl = (hp_max - int'(hp)) / hp_step;
    return lvl[2:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first request at or after ptr wins
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IDXW    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDXW-1:0]    grant_idx,
  output logic               any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/hp_hit_controller.sv
// rtl/hp_hit_controller.sv - HP hit sequencer with arbitration and invulnerability; optional HP_INVULN_EN
module hp_hit_controller
  import hp_ctrl_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int HP_MAX        = HP_MAX_DEF,
  parameter int HP_STEP       = HP_STEP_DEF,
  parameter int INVULN_FRAMES = INVULN_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [NUM_SRC-1:0] hit_req,
  input  logic               restore,
  output logic [NUM_SRC-1:0] hit_ack,
  output logic [6:0]         hp,
  output logic [2:0]         hp_level,
  output logic               invuln,
  output logic               game_over,
  output logic               game_over_pulse
);

  localparam int IDXW = $clog2(NUM_SRC);

  if (HP_MAX / HP_STEP > 7) begin : g_bad_step
    $error("hp_hit_controller: HP_MAX/HP_STEP exceeds 7");
  end
  if (INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_frames
    $error("hp_hit_controller: INVULN_FRAMES out of 1..255");
  end
  if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_src
    $error("hp_hit_controller: NUM_SRC out of 2..8");
  end

  state_t            state;
  logic [IDXW-1:0]   rr_ptr;
  logic [NUM_SRC-1:0] grant;
  logic [IDXW-1:0]   grant_idx;
  logic              any_req;
  logic [6:0]        hp_dec;
  logic [IDXW-1:0]   ptr_next;
`ifdef HP_INVULN_EN
  logic [7:0]        inv_cnt;
`endif

  rr_arbiter #(.NUM_SRC(NUM_SRC), .IDXW(IDXW)) u_arb (
    .req       (hit_req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  always_comb begin
    hp_dec   = (hp > 7'(HP_STEP)) ? hp - 7'(HP_STEP) : 7'd0;
    ptr_next = (grant_idx == IDXW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state           <= ALIVE_ST;
      rr_ptr          <= '0;
      hp              <= 7'(HP_MAX);
      hp_level        <= 3'd0;
      hit_ack         <= '0;
      invuln          <= 1'b0;
      game_over       <= 1'b0;
      game_over_pulse <= 1'b0;
`ifdef HP_INVULN_EN
      inv_cnt         <= 8'd0;
`endif
    end else begin
      hit_ack         <= '0;
      game_over_pulse <= 1'b0;
      if (restore) begin
        state     <= ALIVE_ST;
        rr_ptr    <= '0;
        hp        <= 7'(HP_MAX);
        hp_level  <= 3'd0;
        invuln    <= 1'b0;
        game_over <= 1'b0;
`ifdef HP_INVULN_EN
        inv_cnt   <= 8'd0;
`endif
      end else begin
        case (state)
          ALIVE_ST: begin
            if (any_req) begin
              hit_ack  <= grant;
              rr_ptr   <= ptr_next;
              hp       <= hp_dec;
              hp_level <= hp_level_of(hp_dec, HP_MAX, HP_STEP);
              if (hp_dec == 7'd0) begin
                state           <= DEAD_ST;
                game_over       <= 1'b1;
                game_over_pulse <= 1'b1;
              end else begin
                state  <= HIT_ST;
                invuln <= 1'b1;
              end
            end
          end
          HIT_ST: begin
            if (startOfFrame) begin
`ifdef HP_INVULN_EN
              state   <= INVULN_ST;
              inv_cnt <= 8'(INVULN_FRAMES);
`else
              state  <= ALIVE_ST;
              invuln <= 1'b0;
`endif
            end
          end
`ifdef HP_INVULN_EN
          INVULN_ST: begin
            if (startOfFrame) begin
              // A count of 0 here can only come from corruption; treat it as expired.
              if (inv_cnt <= 8'd1) begin
                inv_cnt <= 8'd0;
                state   <= ALIVE_ST;
                invuln  <= 1'b0;
              end else begin
                inv_cnt <= inv_cnt - 8'd1;
              end
            end
          end
`endif
          DEAD_ST: ;
          default: begin
            state  <= ALIVE_ST;
            invuln <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hp_hit_controller.sv
// tb/tb_hp_hit_controller.sv - self-checking bench for hp_hit_controller against a frame-count reference model
module tb_hp_hit_controller;

  localparam int NS      = 4;
  localparam int HPM     = 100;
  localparam int HPS     = 25;
  localparam int IFRAMES = 2;
`ifdef HP_INVULN_EN
  localparam int PROT = IFRAMES + 1;
`else
  localparam int PROT = 1;
`endif

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          startOfFrame = 1'b0;
  logic [NS-1:0] hit_req = '0;
  logic          restore = 1'b0;
  logic [NS-1:0] hit_ack;
  logic [6:0]    hp;
  logic [2:0]    hp_level;
  logic          invuln;
  logic          game_over;
  logic          game_over_pulse;

  hp_hit_controller #(.NUM_SRC(NS), .HP_MAX(HPM), .HP_STEP(HPS), .INVULN_FRAMES(IFRAMES)) dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .hit_req         (hit_req),
    .restore         (restore),
    .hit_ack         (hit_ack),
    .hp              (hp),
    .hp_level        (hp_level),
    .invuln          (invuln),
    .game_over       (game_over),
    .game_over_pulse (game_over_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int gop_seen = 0;

  // Model: hp, arbitration pointer, frames of protection still to elapse, dead flag.
  int            m_hp = HPM;
  int            m_ptr = 0;
  int            m_prot = 0;
  bit            m_dead = 0;
  logic [NS-1:0] e_ack = '0;
  logic          e_gop = 1'b0;

  task automatic model_step(input logic [NS-1:0] req, input logic sof, input logic rs, input logic rn);
    e_ack = '0;
    e_gop = 1'b0;
    if (!rn || rs) begin
      m_hp = HPM; m_ptr = 0; m_prot = 0; m_dead = 0;
    end else if (m_dead) begin
    end else if (m_prot > 0) begin
      if (sof) m_prot--;
    end else if (req != '0) begin
      for (int k = 0; k < NS; k++) begin
        int idx;
        idx = (m_ptr + k) % NS;
        if (e_ack == '0 && req[idx]) begin
          e_ack[idx] = 1'b1;
          m_ptr = (idx + 1) % NS;
        end
      end
      m_hp = (m_hp > HPS) ? m_hp - HPS : 0;
      if (m_hp == 0) begin
        m_dead = 1;
        e_gop  = 1'b1;
      end else begin
        m_prot = PROT;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    if (game_over_pulse === 1'b1) gop_seen++;
    chk("hit_ack", int'(hit_ack), int'(e_ack));
    chk("hp", int'(hp), m_hp);
    chk("hp_level", int'(hp_level), (HPM - m_hp) / HPS);
    chk("invuln", int'(invuln), (m_prot > 0 && !m_dead) ? 1 : 0);
    chk("game_over", int'(game_over), m_dead ? 1 : 0);
    chk("game_over_pulse", int'(game_over_pulse), int'(e_gop));
  endtask

  task automatic step(input logic [NS-1:0] req, input logic sof, input logic rs, input logic rn);
    hit_req = req; startOfFrame = sof; restore = rs; resetN = rn;
    @(posedge clk);
    model_step(req, sof, rs, rn);
    #1;
    check_outputs();
  endtask

  initial begin
    // Reset state
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);

    // Single hit from source 0
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    chk("first_ack", int'(hit_ack), 1);
    chk("first_hp", int'(hp), 75);
    chk("first_invuln", int'(invuln), 1);

    // Requests while protected are ignored until the protection frames expire
    for (int c = 0; c < 4 * (PROT + 1); c++) step(4'b1111, (c % 4) == 3, 1'b0, 1'b1);

    // Held requests on all sources until game over
    step('0, 1'b0, 1'b1, 1'b1);
    gop_seen = 0;
    for (int c = 0; c < 80; c++) step(4'b1111, (c % 4) == 3, 1'b0, 1'b1);
    chk("dead_game_over", int'(game_over), 1);
    chk("single_pulse", gop_seen, 1);
    chk("dead_hp", int'(hp), 0);
    chk("dead_level", int'(hp_level), HPM / HPS);

    // Bring hp to 25, then restore together with a request
    step('0, 1'b0, 1'b1, 1'b1);
    for (int h = 0; h < 3; h++) begin
      step(4'b0100, 1'b0, 1'b0, 1'b1);
      for (int f = 0; f < PROT; f++) step('0, 1'b1, 1'b0, 1'b1);
    end
    chk("pre_restore_hp", int'(hp), 25);
    step(4'b1111, 1'b0, 1'b1, 1'b1);
    chk("restore_hp", int'(hp), 100);
    chk("restore_ack", int'(hit_ack), 0);

    // Reset mid-protection, then an immediate hit
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b1, 1'b0);
    chk("reset_invuln", int'(invuln), 0);
    step(4'b1000, 1'b0, 1'b0, 1'b1);
    chk("post_reset_ack", int'(hit_ack), 8);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [NS-1:0] r;
      r = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      step(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 150) == 0), ($urandom_range(0, 300) != 0));
    end

    hit_req = '0; startOfFrame = 1'b0; restore = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
